// File: rtl/mean_filter_pkg.sv
// Shared types and constants for the NxN box-mean filter: FSM states,
// kernel geometry helpers and the exact reciprocal used for division by K^2.
package mean_filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Tap counters hold 0..K-1 with K at most 7.
  localparam int TAP_BITS = 3;

  function automatic int kernel_size(input int radius);
    return (32'sd2 * radius) + 32'sd1;
  endfunction

  function automatic int sum_width(input int radius);
    return 32'sd8 + $clog2(kernel_size(radius) * kernel_size(radius));
  endfunction

  // RECIP = ceil(2^24 / K^2); the rounding error times the largest sum stays
  // below 2^24, so (sum * RECIP) >> 24 equals floor(sum / K^2) exactly.
  function automatic int recip_for(input int radius);
    case (radius)
      32'sd1:  return 32'sd1864136;
      32'sd2:  return 32'sd671089;
      32'sd3:  return 32'sd342393;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic int shift_for(input int radius);
    case (radius)
      32'sd1, 32'sd2, 32'sd3: return 32'sd24;
      default:                return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/kernel_tap_addr.sv
// Walks the kernel taps in raster order and turns (pixel, tap) into clamped
// image coordinates plus a flag telling whether the tap fell off the image.
module kernel_tap_addr
  import mean_filter_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2 ** WIDTH_BITS,
  parameter int HEIGHT      = 2 ** HEIGHT_BITS,
  parameter int RADIUS      = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tap_clear,
  input  logic                   tap_advance,
  input  logic [WIDTH_BITS-1:0]  col,
  input  logic [HEIGHT_BITS-1:0] row,
  output logic [WIDTH_BITS-1:0]  tap_col,
  output logic [HEIGHT_BITS-1:0] tap_row,
  output logic                   tap_oob,
  output logic                   tap_last
);

  localparam int K  = kernel_size(RADIUS);
  localparam int CW = WIDTH_BITS + 2;
  localparam int RW = HEIGHT_BITS + 2;
  localparam logic [TAP_BITS-1:0] K_LAST = TAP_BITS'(K - 32'sd1);

  logic [TAP_BITS-1:0] tap_x_r;
  logic [TAP_BITS-1:0] tap_y_r;
  logic signed [CW-1:0] cx_s;
  logic signed [RW-1:0] ry_s;
  logic col_lo_s, col_hi_s, row_lo_s, row_hi_s;

  // Tap counter: x runs fastest, both wrap to 0 after the last tap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tap_x_r <= '0;
      tap_y_r <= '0;
    end else if (tap_clear) begin
      tap_x_r <= '0;
      tap_y_r <= '0;
    end else if (tap_advance) begin
      if (tap_x_r == K_LAST) begin
        tap_x_r <= '0;
        tap_y_r <= (tap_y_r == K_LAST) ? '0 : tap_y_r + TAP_BITS'(1);
      end else begin
        tap_x_r <= tap_x_r + TAP_BITS'(1);
      end
    end
  end

  assign cx_s = $signed(CW'(col)) + $signed(CW'(tap_x_r)) - $signed(CW'(RADIUS));
  assign ry_s = $signed(RW'(row)) + $signed(RW'(tap_y_r)) - $signed(RW'(RADIUS));

  assign col_lo_s = cx_s[CW-1];
  assign col_hi_s = !col_lo_s && (cx_s > $signed(CW'(WIDTH - 32'sd1)));
  assign row_lo_s = ry_s[RW-1];
  assign row_hi_s = !row_lo_s && (ry_s > $signed(RW'(HEIGHT - 32'sd1)));

  assign tap_col  = col_lo_s ? '0 : (col_hi_s ? WIDTH_BITS'(WIDTH - 32'sd1) : WIDTH_BITS'(cx_s));
  assign tap_row  = row_lo_s ? '0 : (row_hi_s ? HEIGHT_BITS'(HEIGHT - 32'sd1) : HEIGHT_BITS'(ry_s));
  assign tap_oob  = col_lo_s | col_hi_s | row_lo_s | row_hi_s;
  assign tap_last = (tap_x_r == K_LAST) && (tap_y_r == K_LAST);

endmodule

// File: rtl/mean_filter_nxn.sv
// Box-mean filter over a whole image: one kernel pass per pixel, reading taps
// from a synchronous image RAM and writing floor(sum/K^2) to a result RAM.
module mean_filter_nxn
  import mean_filter_pkg::*;
#(
  parameter int WIDTH_BITS   = 8,
  parameter int HEIGHT_BITS  = 8,
  parameter int WIDTH        = 2 ** WIDTH_BITS,
  parameter int HEIGHT       = 2 ** HEIGHT_BITS,
  parameter int RADIUS       = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   border_mode,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   busy,
  output logic                   done
);

  localparam int SUM_W   = sum_width(RADIUS);
  localparam int PROD_W  = SUM_W + 32;
  localparam int SHIFT_C = shift_for(RADIUS);
  localparam logic [PROD_W-1:0]      RECIP_C    = PROD_W'(recip_for(RADIUS));
  localparam logic [WIDTH_BITS-1:0]  COL_LAST   = WIDTH_BITS'(WIDTH - 32'sd1);
  localparam logic [HEIGHT_BITS-1:0] ROW_LAST   = HEIGHT_BITS'(HEIGHT - 32'sd1);
  localparam logic [1:0]             DRAIN_LAST =
    2'((READ_LATENCY > 32'sd0) ? (READ_LATENCY - 32'sd1) : 32'sd0);

  state_t                 state_r;
  logic                   zero_mode_r;
  logic [WIDTH_BITS-1:0]  col_r;
  logic [HEIGHT_BITS-1:0] row_r;
  logic [SUM_W-1:0]       sum_r;
  logic [1:0]             drain_cnt_r;

  logic [WIDTH_BITS-1:0]  tap_col_s;
  logic [HEIGHT_BITS-1:0] tap_row_s;
  logic                   tap_oob_s, tap_last_s, issue_s;
  logic [READ_LATENCY:0]  vld_pipe_s, oob_pipe_s;
  logic [SUM_W-1:0]       sum_next_s;
  logic [PROD_W-1:0]      prod_s;
  logic [7:0]             quot_s;

  assign issue_s = (state_r == ST_ACCUM);

  kernel_tap_addr #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .RADIUS     (RADIUS)
  ) u_tap (
    .clock      (clock),
    .reset      (reset),
    .tap_clear  (state_r == ST_IDLE),
    .tap_advance(issue_s),
    .col        (col_r),
    .row        (row_r),
    .tap_col    (tap_col_s),
    .tap_row    (tap_row_s),
    .tap_oob    (tap_oob_s),
    .tap_last   (tap_last_s)
  );

  assign oImageCol = issue_s ? tap_col_s : '0;
  assign oImageRow = issue_s ? tap_row_s : '0;

  // Valid and zero-pad flags travel alongside the RAM read latency.
  assign vld_pipe_s[0] = issue_s;
  assign oob_pipe_s[0] = tap_oob_s & zero_mode_r;

  generate
    if (READ_LATENCY > 0) begin : g_pipe
      logic [READ_LATENCY-1:0] vld_r, oob_r;

      // Delay line aligning tap flags with returning image data
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_r <= '0;
          oob_r <= '0;
        end else begin
          vld_r <= vld_pipe_s[READ_LATENCY-1:0];
          oob_r <= oob_pipe_s[READ_LATENCY-1:0];
        end
      end

      assign vld_pipe_s[READ_LATENCY:1] = vld_r;
      assign oob_pipe_s[READ_LATENCY:1] = oob_r;
    end
  endgenerate

  assign sum_next_s = sum_r + ((vld_pipe_s[READ_LATENCY] && !oob_pipe_s[READ_LATENCY])
                               ? SUM_W'(iImageData) : '0);
  assign prod_s     = PROD_W'(sum_next_s) * RECIP_C;
  assign quot_s     = 8'(prod_s >> SHIFT_C);

  // Frame sequencer; the result is taken from sum_next so the final tap counts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      zero_mode_r <= 1'b0;
      col_r       <= '0;
      row_r       <= '0;
      sum_r       <= '0;
      drain_cnt_r <= 2'd0;
      oResultCol  <= '0;
      oResultRow  <= '0;
      oResultData <= 8'd0;
      oResultWren <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          oResultWren <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            zero_mode_r <= border_mode;
            col_r       <= '0;
            row_r       <= '0;
            sum_r       <= '0;
            busy        <= 1'b1;
            state_r     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          sum_r <= sum_next_s;
          if (tap_last_s) begin
            if (READ_LATENCY == 0) begin
              oResultWren <= 1'b1;
              oResultCol  <= col_r;
              oResultRow  <= row_r;
              oResultData <= quot_s;
              state_r     <= ST_WRITE;
            end else begin
              drain_cnt_r <= 2'd0;
              state_r     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          sum_r <= sum_next_s;
          if (drain_cnt_r == DRAIN_LAST) begin
            oResultWren <= 1'b1;
            oResultCol  <= col_r;
            oResultRow  <= row_r;
            oResultData <= quot_s;
            state_r     <= ST_WRITE;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        ST_WRITE: begin
          oResultWren <= 1'b0;
          sum_r       <= '0;
          if (col_r == COL_LAST) begin
            col_r <= '0;
            if (row_r == ROW_LAST) begin
              row_r   <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              row_r   <= row_r + HEIGHT_BITS'(1);
              state_r <= ST_ACCUM;
            end
          end else begin
            col_r   <= col_r + WIDTH_BITS'(1);
            state_r <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          oResultWren <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
